// File: rtl/radix4_booth_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | radix4_booth_pkg : shared constants and Booth digit types           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package radix4_booth_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int ITER          = DEFAULT_WIDTH / 2;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      POS1 = 3'd1,
      POS2 = 3'd2,
      NEG1 = 3'd3,
      NEG2 = 3'd4
   } digit_sel_t;

   typedef struct packed {
      logic       neg;
      logic [1:0] mag;
   } digit_t;

   function automatic digit_t sel_to_digit(input digit_sel_t sel);
      digit_t d;
      d = '{neg: 1'b0, mag: 2'd0};
      case (sel)
         POS1:    d = '{neg: 1'b0, mag: 2'd1};
         POS2:    d = '{neg: 1'b0, mag: 2'd2};
         NEG1:    d = '{neg: 1'b1, mag: 2'd1};
         NEG2:    d = '{neg: 1'b1, mag: 2'd2};
         default: d = '{neg: 1'b0, mag: 2'd0};
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/radix4_booth_booth_digit_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | radix4_booth_booth_digit_encoder : triplet -> Booth digit select    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module radix4_booth_booth_digit_encoder
   import radix4_booth_pkg::*;
(
   input  logic [2:0] triplet,
   output digit_t     digit
);

   digit_sel_t sel;

   always_comb begin
      sel = ZERO;
      case (triplet)
         3'b001, 3'b010: sel = POS1;
         3'b011:         sel = POS2;
         3'b100:         sel = NEG2;
         3'b101, 3'b110: sel = NEG1;
         default:        sel = ZERO;
      endcase
   end

   assign digit = sel_to_digit(sel);

endmodule
`default_nettype wire

// File: rtl/radix4_booth.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | radix4_booth : sequential signed radix-4 Booth multiplier           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module radix4_booth
   import radix4_booth_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic [2*WIDTH-1:0] out
);

   localparam int ITERS = WIDTH / 2;
   localparam int CW    = $clog2(ITERS) + 1;
   localparam int PW    = 2 * WIDTH;

   localparam logic [1:0] ST_START = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [PW-1:0] mcand;
   logic [PW-1:0] acc;
   logic [WIDTH:0] mplr;

   logic [PW-1:0] m_cur;
   logic [PW-1:0] term;
   logic [PW-1:0] addend;
   logic [PW-1:0] sum;
   logic [2:0]    triplet;
   logic          last;
   digit_t        digit;

   radix4_booth_booth_digit_encoder u_enc (
      .triplet (triplet),
      .digit   (digit)
   );

   // Digit 0 is taken straight from the ports so it is folded into the latch edge.
   always_comb begin
      if (state == ST_RUN) begin
         m_cur   = mcand;
         triplet = mplr[2:0];
      end else begin
         m_cur   = {{WIDTH{x[WIDTH-1]}}, x};
         triplet = {y[1:0], 1'b0};
      end

      case (digit.mag)
         2'd1:    term = m_cur;
         2'd2:    term = {m_cur[PW-2:0], 1'b0};
         default: term = '0;
      endcase

      addend = digit.neg ? ~term : term;
      sum    = acc + addend + PW'(digit.neg);
      last   = (state == ST_RUN) ? (cnt == CW'(ITERS - 1)) : (ITERS == 1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_START;
         cnt   <= '0;
         mcand <= '0;
         acc   <= '0;
         mplr  <= '0;
         out   <= '0;
      end else begin
         case (state)
            ST_START, ST_RUN: begin
               acc   <= sum;
               mcand <= {m_cur[PW-3:0], 2'b00};
               mplr  <= (state == ST_RUN) ? {2'b00, mplr[WIDTH:2]}
                                          : {2'b00, y[WIDTH-1:1]};
               cnt   <= cnt + 1'b1;
               if (last) begin
                  out   <= sum;
                  state <= ST_DONE;
               end else begin
                  state <= ST_RUN;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_radix4_booth.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_radix4_booth : randomized and directed bench for radix4_booth    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_radix4_booth;

   localparam int W = 32;

   logic          clk   = 1'b0;
   logic          reset = 1'b0;
   logic [W-1:0]  x     = '0;
   logic [W-1:0]  y     = '0;
   logic [2*W-1:0] out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   radix4_booth #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .x     (x),
      .y     (y),
      .out   (out)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
   endfunction

   // Counts edges from release; out must be 0 until edge 16 and then hold the product.
   task automatic wait_result(input logic [31:0] a, input logic [31:0] b,
                              input string tag, input bit scramble);
      for (int e = 1; e <= W/2; e++) begin
         @(posedge clk);
         #1;
         if (e == 1 && scramble) begin
            x = $urandom;
            y = $urandom;
         end
         if (e < W/2)
            check($sformatf("%s/e%0d", tag, e), out, 64'd0);
         else
            check($sformatf("%s/result", tag), out, ref_prod(a, b));
      end
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("%s/hold", tag), out, ref_prod(a, b));
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b,
                      input string tag, input bit scramble);
      @(negedge clk);
      #1;
      reset = 1'b0;
      x     = a;
      y     = b;
      #1;
      check($sformatf("%s/rst", tag), out, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      wait_result(a, b, tag, scramble);
   endtask

   initial begin
      #1;
      check("por", out, 64'd0);

      run(32'd4,        32'd2,        "pp_4x2",    1'b0);
      run(32'd8,        32'd8,        "pp_8x8",    1'b1);
      run(32'd8,        32'hFFFF_FFFE, "pn_8xm2",  1'b1);
      run(32'hFFFF_FFFE, 32'd8,       "np_m2x8",   1'b1);
      run(32'hFFFF_FFFE, 32'd1,       "np_m2x1",   1'b0);
      run(32'hFFFF_FFF4, 32'hFFFF_FFFE, "nn_m12xm2", 1'b1);
      run(32'hFFFF_FFFE, 32'd0,       "zero_y",    1'b1);
      run(32'h8000_0000, 32'h8000_0000, "min_min", 1'b1);
      run(32'h7FFF_FFFF, 32'h8000_0000, "max_min", 1'b1);
      run(32'h7FFF_FFFF, 32'h7FFF_FFFF, "max_max", 1'b1);

      // Abort at edge 7, then restart with new operands.
      @(negedge clk);
      reset = 1'b0;
      x = 32'd100;
      y = 32'hFFFF_FF00;
      @(negedge clk);
      reset = 1'b1;
      repeat (7) @(posedge clk);
      #2;
      reset = 1'b0;
      x = 32'd3;
      y = 32'hFFFF_FFFB;
      #1;
      check("abort/out", out, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      wait_result(32'd3, 32'hFFFF_FFFB, "abort_3xm5", 1'b1);

      for (int i = 0; i < 20; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         if (i % 5 == 0) rb = $urandom_range(0, 15) - 8;
         run(ra, rb, $sformatf("rand%0d", i), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/radix4_booth.md
Name: radix4_booth

Overview:
Sequential signed multiplier using radix-4 (modified) Booth recoding. It computes the full-width two's-complement product of two WIDTH-bit operands, one Booth digit per clock. It serves as the integer mantissa/product engine inside the FloatMultiplier datapath. Each multiply runs once per reset release; reset is the only start mechanism.

Parameters:
WIDTH, 32, operand width in bits; must be even; iteration count is WIDTH/2.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; low clears all state; releasing it (going high) starts a multiply
x  input  WIDTH  multiplicand, two's-complement signed
y  input  WIDTH  multiplier, two's-complement signed, Booth-recoded
out  output  2*WIDTH  signed product x*y; 0 until the multiply completes, then held

Behaviour:
- Interface rule: one clock (clk), reset asynchronous active-low, no synchronous reset.
- While reset=0: out=0, accumulator=0, iteration counter=0, busy/done flags cleared, regardless of clk.
- Reset deassertion to 1 starts the multiply. x and y must be stable from reset release through the first rising edge.
- Edge 1 after release: latch x (sign-extended to 2*WIDTH) and y (with an implicit y[-1]=0 appended). Process Booth digit 0 in the same edge.
- Edges 2..WIDTH/2: process digits 1..WIDTH/2-1, one per edge. Operand input changes after edge 1 are ignored.
- Digit i uses triplet {y[2i+1], y[2i], y[2i-1]}:
  - 000 or 111 -> 0
  - 001 or 010 -> +M
  - 011 -> +2M
  - 100 -> -2M
  - 101 or 110 -> -M
- The term is sign-extended to 2*WIDTH bits, shifted left by 2i and added modulo 2^(2*WIDTH). The -M and -2M terms use two's complement (invert plus carry-in).
- Latency: out is valid after rising edge WIDTH/2 (16 for WIDTH=32) following reset release. No later than that edge.
- out stays 0 during computation and is written once, at the final iteration edge.
- After completion the block is idle. out holds the product, and no further multiply starts until reset is pulsed low and released again.
- Result is the exact signed product; no overflow is possible in 2*WIDTH bits. Corner case: most-negative times most-negative gives +2^(2*WIDTH-2).
- Reset asserted mid-operation aborts immediately: out=0 and counter=0. The next release restarts from edge 1 with the then-current x and y.
- Zero operand gives out=0 after completion, not early termination. Latency is fixed.

Decomposition:
- Shared package holds:
  - the WIDTH default;
  - the Booth digit select encoding (ZERO, POS1, POS2, NEG1, NEG2) as a typedef;
  - the ITER = WIDTH/2 constant.
- One natural sub-module: booth_digit_encoder. It is combinational, taking the 3-bit triplet and producing the digit select (magnitude 0/1/2 plus negate flag).
- The top block holds:
  - the counter;
  - the latched multiplicand;
  - the shift/select of the multiplier triplet;
  - the 2*WIDTH accumulator and adder;
  - the out register.

Test Plan:
- +*+ : x=4, y=2, reset released, wait 16 edges -> out=0x0000_0000_0000_0008. Also x=8, y=8 -> 0x40.
- +*- and -*+ : x=8, y=-2 (0xFFFF_FFFE) -> out=0xFFFF_FFFF_FFFF_FFF0. x=-2, y=8 -> same value. x=-2, y=1 -> 0xFFFF_FFFF_FFFF_FFFE.
- -*- : x=-12 (0xFFFF_FFF4), y=-2 -> out=0x0000_0000_0000_0018.
- Zero and extremes:
  - x=-2, y=0 -> out=0.
  - x=y=0x8000_0000 -> out=0x4000_0000_0000_0000.
  - x=0x7FFF_FFFF, y=0x8000_0000 -> out=0xC000_0000_8000_0000.
- Timing: out=0 at edges 1..15 after release and equals the product exactly at edge 16. Changing x/y after edge 1 does not alter the result.
- Reset mid-op: assert reset low at edge 7 -> out=0 immediately (asynchronous). Release with new operands x=3, y=-5 -> out=0xFFFF_FFFF_FFFF_FFF1 after 16 edges.
